// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Parametrised single-clock FIFO used as the UART TX/RX buffer and as a
//   general SoC staging queue. Supports any depth >= 2 (not only powers of
//   two), an explicit occupancy count, programmable almost-full/almost-empty
//   thresholds, registered or show-ahead (FWFT) read mode, a synchronous
//   flush and sticky overflow/underflow flags.
//
// Parameters
//   DataWidth   bits per entry
//   Depth       number of entries (>= 2, any integer)
//   Fwft        0: rdata_o registered one cycle after a pop
//               1: rdata_o shows the head entry combinationally
//   AfullLevel  almost_full_o  when count >= AfullLevel  (1..Depth)
//   AemptyLevel almost_empty_o when count <= AemptyLevel (0..Depth-1)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   flush_i        synchronous clear of contents and error flags
//   wr_en_i/wdata_i push request and data
//   rd_en_i        pop request (in FWFT mode: acknowledge of the shown word)
//   rdata_o        read data, qualified by rvalid_o
//   full_o/empty_o/almost_full_o/almost_empty_o  status decoded from count
//   count_o        current occupancy
//   overflow_o     sticky: push refused because the FIFO was full
//   underflow_o    sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned Depth       = 16,
  parameter bit          Fwft        = 1'b0,
  parameter int unsigned AfullLevel  = Depth - 2,
  parameter int unsigned AemptyLevel = 2,
  localparam int unsigned CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DataWidth-1:0]  wdata_i,
  input  logic                  rd_en_i,
  output logic [DataWidth-1:0]  rdata_o,
  output logic                  rvalid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CountWidth-1:0] count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [CountWidth-1:0] FullCount  = CountWidth'(Depth);
  localparam logic [CountWidth-1:0] AfullCount = CountWidth'(AfullLevel);
  localparam logic [CountWidth-1:0] AemptyCount = CountWidth'(AemptyLevel);
  localparam logic [IdxWidth-1:0]   IdxLast    = IdxWidth'(Depth - 1);

  // Parameter legality is checked at elaboration time.
  if (Depth < 2) begin : g_err_depth
    $error("sync_fifo: Depth must be >= 2");
  end
  if (AfullLevel < 1 || AfullLevel > Depth) begin : g_err_afull
    $error("sync_fifo: AfullLevel must be in 1..Depth");
  end
  if (AemptyLevel > Depth - 1) begin : g_err_aempty
    $error("sync_fifo: AemptyLevel must be in 0..Depth-1");
  end

  // Index increment with explicit wrap at Depth-1, so non-power-of-two
  // depths need no wrap bit.
  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
    return (idx == IdxLast) ? '0 : idx + IdxWidth'(1);
  endfunction

  logic [DataWidth-1:0]  mem_q [Depth];
  logic [IdxWidth-1:0]   wr_idx_q;
  logic [IdxWidth-1:0]   rd_idx_q;
  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;
  logic                  overflow_q;
  logic                  underflow_q;

  logic full;
  logic empty;
  logic rd_acc;
  logic wr_acc;
  logic overflow_set;
  logic underflow_set;

  // Status decode, all from the occupancy count.
  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AfullCount);
  assign almost_empty_o = (count_q <= AemptyCount);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // A push into a full FIFO still succeeds when a pop frees a slot in the
  // same cycle; a pop from an empty FIFO never succeeds, even with a push.
  assign rd_acc = rd_en_i && !empty && !flush_i;
  assign wr_acc = wr_en_i && !flush_i && (!full || rd_acc);

  assign overflow_set  = wr_en_i && full && !rd_acc && !flush_i;
  assign underflow_set = rd_en_i && empty && !flush_i;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CountWidth'(1);
      2'b01:   count_d = count_q - CountWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Stage p0: indices, occupancy and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_idx_q <= next_idx(wr_idx_q);
      if (rd_acc) rd_idx_q <= next_idx(rd_idx_q);
      count_q <= count_d;
      if (overflow_set)  overflow_q  <= 1'b1;
      if (underflow_set) underflow_q <= 1'b1;
    end
  end

  // Storage is never cleared; reset/flush only move the indices.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_idx_q] <= wdata_i;
  end

  if (Fwft) begin : g_fwft
    // Head entry is always on the output; rd_en_i acknowledges it.
    assign rdata_o  = mem_q[rd_idx_q];
    assign rvalid_o = !empty;
  end else begin : g_reg
    logic [DataWidth-1:0] rdata_p1;
    logic                 vld_p1;

    // Stage p1: registered read data; rdata holds when nothing is popped.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdata_p1 <= '0;
        vld_p1   <= 1'b0;
      end else begin
        vld_p1 <= rd_acc;
        if (rd_acc) rdata_p1 <= mem_q[rd_idx_q];
      end
    end

    assign rdata_o  = rdata_p1;
    assign rvalid_o = vld_p1;
  end

endmodule
